// File: rtl/if_fetch_pkg.sv
// Shared fetch-stage definitions: bus widths, control encodings and IF state encodings.
package if_fetch_pkg;

  localparam int unsigned InstAddrBus = 32;
  localparam int unsigned InstBus     = 32;

  localparam logic [InstBus-1:0] ZeroWord = InstBus'(0);

  localparam logic Stop        = 1'b1;
  localparam logic NoStop      = 1'b0;
  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;

  typedef enum logic {
    IF_S_IDLE = 1'b0,
    IF_S_RUN  = 1'b1
  } if_state_e;

  // Sequential fetch address; wraps modulo 2^32.
  function automatic logic [InstAddrBus-1:0] pc_inc(input logic [InstAddrBus-1:0] pc);
    return pc + InstAddrBus'(4);
  endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, drives a request/ack instruction memory port,
// buffers an instruction across pipeline stalls and applies delay-slot branch redirects.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [InstAddrBus-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [5:0]             stall,
  input  logic                   branch_flag_i,
  input  logic [InstAddrBus-1:0] branch_target_i,
  input  logic                   imem_ack_i,
  input  logic [InstBus-1:0]     imem_data_i,
  output logic                   ce_o,
  output logic [InstAddrBus-1:0] imem_addr_o,
  output logic [InstAddrBus-1:0] if_pc,
  output logic [InstBus-1:0]     if_inst,
  output logic                   stallreq_o
);

  if_state_e              r_state;
  if_state_e              w_state_nxt;
  logic [InstAddrBus-1:0] r_pc;
  logic                   r_buf_valid;
  logic [InstBus-1:0]     r_inst_buf;
  logic                   r_redir_pend;
  logic [InstAddrBus-1:0] r_redir_tgt;

  logic                   w_run;
  logic                   w_stop;
  logic                   w_avail;
  logic                   w_advance;
  logic                   w_hold;
  logic                   w_branch_cap;
  logic [InstAddrBus-1:0] w_next_pc;
  logic                   w_unused_stall;

  // Only the fetch-stage bit of the stall vector concerns this stage.
  assign w_unused_stall = ^stall[5:1];

  assign w_run        = (r_state == IF_S_RUN);
  assign w_stop       = (stall[0] == Stop);
  assign w_avail      = w_run & (r_buf_valid | imem_ack_i);
  assign w_advance    = w_avail & ~w_stop;
  assign w_hold       = w_run & imem_ack_i & ~r_buf_valid & w_stop;
  assign w_branch_cap = w_run & branch_flag_i & ~w_advance;

  // A live branch overrides an older pending redirect.
  always_comb begin
    w_next_pc = pc_inc(r_pc);
    if (branch_flag_i) begin
      w_next_pc = branch_target_i;
    end else if (r_redir_pend) begin
      w_next_pc = r_redir_tgt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IF_S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and port outputs; idle spends one cycle with the memory disabled.
  always_comb begin
    w_state_nxt = r_state;
    ce_o        = ChipDisable;
    if_inst     = ZeroWord;
    stallreq_o  = 1'b0;
    case (r_state)
      IF_S_IDLE: begin
        w_state_nxt = IF_S_RUN;
      end
      IF_S_RUN: begin
        ce_o       = r_buf_valid ? ChipDisable : ChipEnable;
        stallreq_o = ~(r_buf_valid | imem_ack_i);
        if (r_buf_valid) begin
          if_inst = r_inst_buf;
        end else if (imem_ack_i) begin
          if_inst = imem_data_i;
        end
      end
      default: begin
        w_state_nxt = IF_S_IDLE;
      end
    endcase
  end

  assign imem_addr_o = r_pc;
  assign if_pc       = r_pc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc         <= RESET_PC;
      r_buf_valid  <= 1'b0;
      r_inst_buf   <= ZeroWord;
      r_redir_pend <= 1'b0;
      r_redir_tgt  <= InstAddrBus'(0);
    end else if (w_advance) begin
      r_pc         <= w_next_pc;
      r_buf_valid  <= 1'b0;
      r_redir_pend <= 1'b0;
    end else begin
      if (w_hold) begin
        r_inst_buf  <= imem_data_i;
        r_buf_valid <= 1'b1;
      end
      if (w_branch_cap) begin
        r_redir_pend <= 1'b1;
        r_redir_tgt  <= branch_target_i;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Randomized bench for if_fetch: a variable-latency memory model drives the fetch port and
// a transaction-level model of the fetch stream predicts every output each cycle.
module tb_if_fetch;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF0;
  localparam int unsigned NCYC   = 4000;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic        ce_o;
  logic [31:0] imem_addr_o;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_o;

  int n_checks = 0;
  int n_errors = 0;

  if_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
    .ce_o(ce_o), .imem_addr_o(imem_addr_o), .if_pc(if_pc),
    .if_inst(if_inst), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Fetch-stream model: address being fetched, instruction already in hand, queued redirect.
  logic        m_running;
  logic [31:0] m_pc;
  logic        m_have;
  logic [31:0] m_inst;
  logic        m_pend;
  logic [31:0] m_tgt;

  // Memory model: latency chosen per request, ack only while a request is raised.
  logic        mem_busy;
  int unsigned mem_lat;

  logic [31:0] exp_inst;
  logic        got_inst;
  logic        stop;
  int unsigned redirects;
  int unsigned wraps;

  initial begin
    rst = 1'b0; stall = '0; branch_flag_i = 1'b0; branch_target_i = '0;
    imem_ack_i = 1'b0; imem_data_i = '0;
    m_running = 1'b0; m_pc = RST_PC; m_have = 1'b0; m_inst = '0; m_pend = 1'b0; m_tgt = '0;
    mem_busy = 1'b0; mem_lat = 0; redirects = 0; wraps = 0;
    repeat (2) @(negedge clk);

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      rst             = ($urandom_range(0, 99) < 1) ? 1'b0 : 1'b1;
      stall           = 6'($urandom);
      stall[0]        = ($urandom_range(0, 99) < 35);
      branch_flag_i   = m_running && ($urandom_range(0, 99) < 15);
      branch_target_i = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                    : 32'($urandom);
      imem_ack_i      = 1'b0;
      imem_data_i     = 32'($urandom);
      #1;
      if (!rst || !m_running) begin
        // Acks outside an active fetch (reset cycle, idle cycle) must be ignored.
        imem_ack_i = ($urandom_range(0, 1) == 1);
        mem_busy   = 1'b0;
      end else if (ce_o) begin
        if (!mem_busy) begin
          mem_busy = 1'b1;
          mem_lat  = $urandom_range(0, 3);
        end
        if (mem_lat == 0) begin
          imem_ack_i = 1'b1;
          mem_busy   = 1'b0;
        end else begin
          mem_lat--;
        end
      end else begin
        mem_busy = 1'b0;
      end
      #1;

      stop     = stall[0];
      got_inst = m_running && (m_have || imem_ack_i);
      exp_inst = !m_running ? 32'h0 : m_have ? m_inst : imem_ack_i ? imem_data_i : 32'h0;
      if (rst) begin
        check("ce_o",        32'(ce_o),       32'(m_running && !m_have));
        check("stallreq_o",  32'(stallreq_o), 32'(m_running && !got_inst));
        check("if_pc",       if_pc,           m_pc);
        check("imem_addr_o", imem_addr_o,     m_pc);
        check("if_inst",     if_inst,         exp_inst);
      end

      // Advance the model to the state after this posedge.
      if (!rst) begin
        m_running = 1'b0; m_pc = RST_PC; m_have = 1'b0; m_pend = 1'b0;
      end else if (!m_running) begin
        m_running = 1'b1;
      end else if (got_inst && !stop) begin
        if (branch_flag_i || m_pend) redirects++;
        if (m_pc == 32'hFFFF_FFFC && !branch_flag_i && !m_pend) wraps++;
        m_pc   = branch_flag_i ? branch_target_i : m_pend ? m_tgt : m_pc + 32'd4;
        m_have = 1'b0;
        m_pend = 1'b0;
      end else begin
        if (imem_ack_i && !m_have && stop) begin
          m_have = 1'b1;
          m_inst = imem_data_i;
        end
        if (branch_flag_i) begin
          m_pend = 1'b1;
          m_tgt  = branch_target_i;
        end
      end
    end

    @(negedge clk);
    if (redirects == 0) check("redirects_seen", 32'(redirects), 32'd1);
    if (wraps == 0)     check("pc_wrap_seen",   32'(wraps),     32'd1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
